// File: rtl/multdiv_sequencer.sv
// Iterative multiply/divide unit with HI/LO registers for a multicycle MIPS datapath.
// A WIDTH-step shift-add or restoring-divide loop runs on unsigned magnitudes; FIXUP restores signs.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic [2:0]       state_out
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_RUN   = 3'd2,
        S_FIXUP = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state;
    logic [1:0]         op_reg;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     rem;
    logic [CNT_W-1:0]   cnt;
    logic               sign_a;
    logic               sign_x;
    logic               dz_flag;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    logic               op_signed;
    logic               is_div;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_trial;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_signed = ~op_reg[0];
    assign is_div    = op_reg[1];
    assign a_abs     = (op_signed && a_reg[WIDTH-1]) ? neg_w(a_reg) : a_reg;
    assign b_abs     = (op_signed && b_reg[WIDTH-1]) ? neg_w(b_reg) : b_reg;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                   + (acc[0] ? {1'b0, a_reg} : {(WIDTH+1){1'b0}});

    // Divide: dividend bits leave acc[WIDTH-1:0] from the top while quotient bits enter below.
    assign div_trial = {rem, acc[WIDTH-1]} - {2'b00, b_reg};

    assign prod_fix = sign_x ? neg_2w(acc) : acc;
    assign quot_fix = sign_x ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    assign rem_fix  = sign_a ? neg_w(rem[WIDTH-1:0]) : rem[WIDTH-1:0];

    always_ff @(posedge Clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            Hi      <= '0;
            Lo      <= '0;
            cnt     <= '0;
            dz_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (hi_we) Hi <= wdata;
                    if (lo_we) Lo <= wdata;
                    dz_flag <= 1'b0;
                    if (start) begin
                        op_reg <= op;
                        a_reg  <= A;
                        b_reg  <= B;
                        state  <= S_SETUP;
                    end else begin
                        state  <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    sign_a <= op_signed & a_reg[WIDTH-1];
                    sign_x <= op_signed & (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]);
                    if (is_div && b_reg == '0) begin
                        dz_flag <= 1'b1;
                        state   <= S_DONE;
                    end else begin
                        a_reg <= a_abs;
                        b_reg <= b_abs;
                        acc   <= {{WIDTH{1'b0}}, (is_div ? a_abs : b_abs)};
                        rem   <= '0;
                        cnt   <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        rem <= div_trial[WIDTH+1] ? {rem[WIDTH-1:0], acc[WIDTH-1]}
                                                  : div_trial[WIDTH:0];
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], ~div_trial[WIDTH+1]};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) state <= S_FIXUP;
                end
                S_FIXUP: begin
                    if (is_div) begin
                        Lo <= quot_fix;
                        Hi <= rem_fix;
                    end else begin
                        {Hi, Lo} <= prod_fix;
                    end
                    state <= S_DONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign state_out = state;
    assign busy      = (state == S_SETUP) || (state == S_RUN) || (state == S_FIXUP);
    assign done      = (state == S_DONE);
    assign div_zero  = (state == S_DONE) && dz_flag;

endmodule
